// File: rtl/reorder_buf.sv
// -----------------------------------------------------------------------------
// reorder_buf
//   Circular reorder buffer for an out-of-order core. Instructions are issued
//   in program order at the tail, receive results out of order from the common
//   data bus (CDB), and retire in order from the head. A committing branch whose
//   actual direction differs from its prediction flushes the whole buffer and
//   raises clear_flag for one cycle together with the redirect PC.
//
// Ports
//   clk_in, rst_in            clock, synchronous active-high reset
//   rdy_in                    global enable; low freezes every register
//   issue_*                   decoder offer: rd, branch flag, prediction, alt PC
//   full                      issue not accepted this cycle
//   issue_rob_id              slot the offered instruction would take (tail)
//   new_reg_id / new_ROB_id   rename notification to the register file
//   cdb_*                     result broadcast (slot, value, branch outcome)
//   write_reg_id/_ROB_id/_val commit port to the register file
//   rs1_* / rs2_*             combinational operand lookup with CDB bypass
//   clear_flag, redirect_pc   one-cycle pipeline flush and fetch target
// -----------------------------------------------------------------------------
`ifndef ROB_WIDTH_BIT
`define ROB_WIDTH_BIT 3
`endif

module reorder_buf #(
  parameter int ROB_WIDTH_BIT = `ROB_WIDTH_BIT
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     rdy_in,
  input  logic                     issue_valid,
  input  logic [4:0]               issue_rd,
  input  logic                     issue_is_branch,
  input  logic                     issue_pred_taken,
  input  logic [31:0]              issue_alt_pc,
  output logic                     full,
  output logic [ROB_WIDTH_BIT-1:0] issue_rob_id,
  output logic [4:0]               new_reg_id,
  output logic [ROB_WIDTH_BIT-1:0] new_ROB_id,
  input  logic                     cdb_valid,
  input  logic [ROB_WIDTH_BIT-1:0] cdb_rob_id,
  input  logic [31:0]              cdb_val,
  input  logic                     cdb_taken,
  output logic [4:0]               write_reg_id,
  output logic [ROB_WIDTH_BIT-1:0] write_ROB_id,
  output logic [31:0]              write_val,
  input  logic [ROB_WIDTH_BIT-1:0] rs1_id,
  input  logic [ROB_WIDTH_BIT-1:0] rs2_id,
  output logic                     rs1_ready,
  output logic                     rs2_ready,
  output logic [31:0]              rs1_val,
  output logic [31:0]              rs2_val,
  output logic                     clear_flag,
  output logic [31:0]              redirect_pc
);

  localparam int W     = ROB_WIDTH_BIT;
  localparam int DEPTH = 1 << W;
  localparam int CW    = W + 1;  // count must represent DEPTH itself
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  // Control state (reset)
  logic [W-1:0]     head_q;
  logic [W-1:0]     tail_q;
  logic [CW-1:0]    count_q;
  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] ready_q;
  logic             clear_q;
  logic [31:0]      redirect_q;

  // Entry payload (not reset; only meaningful while the slot is busy)
  logic [4:0]       rd_q       [DEPTH];
  logic [31:0]      value_q    [DEPTH];
  logic             br_q       [DEPTH];
  logic             pred_q     [DEPTH];
  logic             taken_q    [DEPTH];
  logic [31:0]      alt_q      [DEPTH];

  logic accept;
  logic commit;
  logic mispredict;
  logic cdb_hit;

  // clear_flag and rdy_in=0 both make the buffer look full, so a single
  // term gates issue for stalls, flush cycles and real capacity.
  assign full       = (count_q == FULL_COUNT) || clear_q || !rdy_in;
  assign accept     = issue_valid && !full;
  // Commit looks only at stored ready: a result arriving on the CDB this
  // cycle retires on the next one.
  assign commit     = rdy_in && !clear_q && busy_q[head_q] && ready_q[head_q];
  assign mispredict = commit && br_q[head_q] && (taken_q[head_q] != pred_q[head_q]);
  // Broadcasts for freed slots are stale (e.g. from flushed work) and dropped.
  assign cdb_hit    = rdy_in && !clear_q && cdb_valid && busy_q[cdb_rob_id];

  // ---------------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      busy_q     <= '0;
      ready_q    <= '0;
      clear_q    <= 1'b0;
      redirect_q <= '0;
    end else if (rdy_in) begin
      clear_q <= mispredict;
      if (mispredict) begin
        // Flush wins over any same-cycle issue or CDB update.
        redirect_q <= alt_q[head_q];
        head_q     <= '0;
        tail_q     <= '0;
        count_q    <= '0;
        busy_q     <= '0;
        ready_q    <= '0;
      end else begin
        if (cdb_hit) begin
          ready_q[cdb_rob_id] <= 1'b1;
        end
        // Issue and commit never target the same slot: issue needs
        // count<DEPTH, commit needs a busy head, and head==tail then means
        // the buffer is empty.
        if (accept) begin
          busy_q[tail_q]  <= 1'b1;
          ready_q[tail_q] <= 1'b0;
          tail_q          <= tail_q + W'(1);
        end
        if (commit) begin
          busy_q[head_q]  <= 1'b0;
          ready_q[head_q] <= 1'b0;
          head_q          <= head_q + W'(1);
        end
        count_q <= count_q + CW'(accept) - CW'(commit);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Entry payload storage
  // ---------------------------------------------------------------------------
  // NOTE: the payload array has no reset; busy/ready qualify every read, so
  // clearing the data would only add reset fan-out to a RAM-like structure.
  always_ff @(posedge clk_in) begin
    if (rdy_in) begin
      if (cdb_hit) begin
        value_q[cdb_rob_id] <= cdb_val;
        taken_q[cdb_rob_id] <= cdb_taken;
      end
      if (accept) begin
        rd_q[tail_q]   <= issue_rd;
        br_q[tail_q]   <= issue_is_branch;
        pred_q[tail_q] <= issue_pred_taken;
        alt_q[tail_q]  <= issue_alt_pc;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Operand lookup with CDB bypass
  // ---------------------------------------------------------------------------
  // NOTE: every always_comb output is given a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    rs1_ready = ready_q[rs1_id];
    rs1_val   = value_q[rs1_id];
    rs2_ready = ready_q[rs2_id];
    rs2_val   = value_q[rs2_id];
    if (cdb_valid && (cdb_rob_id == rs1_id)) begin
      rs1_ready = 1'b1;
      rs1_val   = cdb_val;
    end
    if (cdb_valid && (cdb_rob_id == rs2_id)) begin
      rs2_ready = 1'b1;
      rs2_val   = cdb_val;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign issue_rob_id = tail_q;
  assign new_reg_id   = accept ? issue_rd : 5'd0;
  assign new_ROB_id   = tail_q;
  assign write_reg_id = commit ? rd_q[head_q] : 5'd0;
  assign write_ROB_id = head_q;
  assign write_val    = value_q[head_q];
  assign clear_flag   = clear_q;
  assign redirect_pc  = redirect_q;

endmodule

// File: tb/tb_reorder_buf.sv
// -----------------------------------------------------------------------------
// tb_reorder_buf
//   Directed, self-checking bench for reorder_buf (default 8 entries).
//   Inputs change 1 time unit after the rising edge; outputs are compared
//   2 time units after the edge, well away from the next one.
// -----------------------------------------------------------------------------
module tb_reorder_buf;

  localparam int W = 3;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic          rdy_in;
  logic          issue_valid;
  logic [4:0]    issue_rd;
  logic          issue_is_branch;
  logic          issue_pred_taken;
  logic [31:0]   issue_alt_pc;
  logic          full;
  logic [W-1:0]  issue_rob_id;
  logic [4:0]    new_reg_id;
  logic [W-1:0]  new_ROB_id;
  logic          cdb_valid;
  logic [W-1:0]  cdb_rob_id;
  logic [31:0]   cdb_val;
  logic          cdb_taken;
  logic [4:0]    write_reg_id;
  logic [W-1:0]  write_ROB_id;
  logic [31:0]   write_val;
  logic [W-1:0]  rs1_id;
  logic [W-1:0]  rs2_id;
  logic          rs1_ready;
  logic          rs2_ready;
  logic [31:0]   rs1_val;
  logic [31:0]   rs2_val;
  logic          clear_flag;
  logic [31:0]   redirect_pc;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_in = ~clk_in;

  reorder_buf #(.ROB_WIDTH_BIT(W)) dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .rdy_in           (rdy_in),
    .issue_valid      (issue_valid),
    .issue_rd         (issue_rd),
    .issue_is_branch  (issue_is_branch),
    .issue_pred_taken (issue_pred_taken),
    .issue_alt_pc     (issue_alt_pc),
    .full             (full),
    .issue_rob_id     (issue_rob_id),
    .new_reg_id       (new_reg_id),
    .new_ROB_id       (new_ROB_id),
    .cdb_valid        (cdb_valid),
    .cdb_rob_id       (cdb_rob_id),
    .cdb_val          (cdb_val),
    .cdb_taken        (cdb_taken),
    .write_reg_id     (write_reg_id),
    .write_ROB_id     (write_ROB_id),
    .write_val        (write_val),
    .rs1_id           (rs1_id),
    .rs2_id           (rs2_id),
    .rs1_ready        (rs1_ready),
    .rs2_ready        (rs2_ready),
    .rs1_val          (rs1_val),
    .rs2_val          (rs2_val),
    .clear_flag       (clear_flag),
    .redirect_pc      (redirect_pc)
  );

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    rst_in           = 1'b0;
    rdy_in           = 1'b1;
    issue_valid      = 1'b0;
    issue_rd         = 5'd0;
    issue_is_branch  = 1'b0;
    issue_pred_taken = 1'b0;
    issue_alt_pc     = 32'd0;
    cdb_valid        = 1'b0;
    cdb_rob_id       = '0;
    cdb_val          = 32'd0;
    cdb_taken        = 1'b0;
    rs1_id           = '0;
    rs2_id           = '0;
  endtask

  task automatic do_reset();
    idle();
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
  endtask

  task automatic issue(input logic [4:0] rd);
    idle();
    issue_valid = 1'b1;
    issue_rd    = rd;
    tick();
  endtask

  task automatic cdb(input logic [W-1:0] id, input logic [31:0] val, input logic tk);
    idle();
    cdb_valid  = 1'b1;
    cdb_rob_id = id;
    cdb_val    = val;
    cdb_taken  = tk;
    tick();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    do_reset();
    idle(); settle();
    n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %0b want 0", full); end
    n_checks++; if (issue_rob_id !== 3'd0) begin n_fail++; $display("FAIL reset_issue_rob_id: got %0d want 0", issue_rob_id); end
    n_checks++; if (new_reg_id !== 5'd0) begin n_fail++; $display("FAIL reset_new_reg_id: got %0d want 0", new_reg_id); end
    n_checks++; if (write_reg_id !== 5'd0) begin n_fail++; $display("FAIL reset_write_reg_id: got %0d want 0", write_reg_id); end
    n_checks++; if (clear_flag !== 1'b0) begin n_fail++; $display("FAIL reset_clear_flag: got %0b want 0", clear_flag); end
    n_checks++; if (redirect_pc !== 32'd0) begin n_fail++; $display("FAIL reset_redirect_pc: got %h want 0", redirect_pc); end
  endtask

  task automatic test_issue_commit();
    do_reset();
    idle(); issue_valid = 1'b1; issue_rd = 5'd5; settle();
    n_checks++; if (new_reg_id !== 5'd5) begin n_fail++; $display("FAIL ic_new_reg_id: got %0d want 5", new_reg_id); end
    n_checks++; if (new_ROB_id !== 3'd0) begin n_fail++; $display("FAIL ic_new_ROB_id: got %0d want 0", new_ROB_id); end
    tick();
    idle(); cdb_valid = 1'b1; cdb_rob_id = 3'd0; cdb_val = 32'h1234; settle();
    n_checks++; if (issue_rob_id !== 3'd1) begin n_fail++; $display("FAIL ic_tail_adv: got %0d want 1", issue_rob_id); end
    n_checks++; if (write_reg_id !== 5'd0) begin n_fail++; $display("FAIL ic_no_early_commit: got %0d want 0", write_reg_id); end
    tick();
    idle(); settle();
    n_checks++; if (write_reg_id !== 5'd5) begin n_fail++; $display("FAIL ic_write_reg_id: got %0d want 5", write_reg_id); end
    n_checks++; if (write_val !== 32'h1234) begin n_fail++; $display("FAIL ic_write_val: got %h want 1234", write_val); end
    n_checks++; if (write_ROB_id !== 3'd0) begin n_fail++; $display("FAIL ic_write_ROB_id: got %0d want 0", write_ROB_id); end
    tick();
    idle(); settle();
    n_checks++; if (write_reg_id !== 5'd0) begin n_fail++; $display("FAIL ic_head_freed: got %0d want 0", write_reg_id); end
    n_checks++; if (write_ROB_id !== 3'd1) begin n_fail++; $display("FAIL ic_head_adv: got %0d want 1", write_ROB_id); end
  endtask

  task automatic test_full_wrap();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      idle(); issue_valid = 1'b1; issue_rd = 5'(i + 1); settle();
      n_checks++; if (issue_rob_id !== 3'(i)) begin n_fail++; $display("FAIL fw_slot%0d: got %0d want %0d", i, issue_rob_id, i); end
      tick();
    end
    idle(); issue_valid = 1'b1; issue_rd = 5'd9; settle();
    n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL fw_full: got %0b want 1", full); end
    n_checks++; if (issue_rob_id !== 3'd0) begin n_fail++; $display("FAIL fw_tail_wrap: got %0d want 0", issue_rob_id); end
    n_checks++; if (new_reg_id !== 5'd0) begin n_fail++; $display("FAIL fw_ninth_rejected: got %0d want 0", new_reg_id); end
    tick();
    cdb(3'd0, 32'hA0, 1'b0);
    // Head commits this cycle, but issue stays blocked: count was 8 at the start.
    idle(); issue_valid = 1'b1; issue_rd = 5'd9; settle();
    n_checks++; if (write_reg_id !== 5'd1) begin n_fail++; $display("FAIL fw_commit: got %0d want 1", write_reg_id); end
    n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL fw_full_during_commit: got %0b want 1", full); end
    n_checks++; if (new_reg_id !== 5'd0) begin n_fail++; $display("FAIL fw_issue_blocked: got %0d want 0", new_reg_id); end
    tick();
    idle(); issue_valid = 1'b1; issue_rd = 5'd9; settle();
    n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL fw_not_full: got %0b want 0", full); end
    n_checks++; if (new_reg_id !== 5'd9) begin n_fail++; $display("FAIL fw_issue_after_commit: got %0d want 9", new_reg_id); end
    tick();
    idle(); settle();
    n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL fw_full_again: got %0b want 1", full); end
  endtask

  task automatic test_out_of_order();
    do_reset();
    issue(5'd3);
    issue(5'd4);
    cdb(3'd1, 32'h11, 1'b0);
    idle(); settle();
    n_checks++; if (write_reg_id !== 5'd0) begin n_fail++; $display("FAIL ooo_hold: got %0d want 0", write_reg_id); end
    tick();
    cdb(3'd0, 32'h22, 1'b0);
    idle(); settle();
    n_checks++; if (write_reg_id !== 5'd3) begin n_fail++; $display("FAIL ooo_first_reg: got %0d want 3", write_reg_id); end
    n_checks++; if (write_val !== 32'h22) begin n_fail++; $display("FAIL ooo_first_val: got %h want 22", write_val); end
    tick();
    idle(); settle();
    n_checks++; if (write_reg_id !== 5'd4) begin n_fail++; $display("FAIL ooo_second_reg: got %0d want 4", write_reg_id); end
    n_checks++; if (write_val !== 32'h11) begin n_fail++; $display("FAIL ooo_second_val: got %h want 11", write_val); end
    n_checks++; if (write_ROB_id !== 3'd1) begin n_fail++; $display("FAIL ooo_second_slot: got %0d want 1", write_ROB_id); end
    tick();
    idle(); settle();
    n_checks++; if (write_reg_id !== 5'd0) begin n_fail++; $display("FAIL ooo_drained: got %0d want 0", write_reg_id); end
  endtask

  task automatic test_bypass();
    do_reset();
    issue(5'd1);
    issue(5'd2);
    issue(5'd3);
    idle(); rs1_id = 3'd2; rs2_id = 3'd1; settle();
    n_checks++; if (rs1_ready !== 1'b0) begin n_fail++; $display("FAIL byp_not_ready: got %0b want 0", rs1_ready); end
    cdb_valid = 1'b1; cdb_rob_id = 3'd2; cdb_val = 32'h55; settle();
    n_checks++; if (rs1_ready !== 1'b1) begin n_fail++; $display("FAIL byp_rs1_ready: got %0b want 1", rs1_ready); end
    n_checks++; if (rs1_val !== 32'h55) begin n_fail++; $display("FAIL byp_rs1_val: got %h want 55", rs1_val); end
    n_checks++; if (rs2_ready !== 1'b0) begin n_fail++; $display("FAIL byp_rs2_other: got %0b want 0", rs2_ready); end
    tick();
    idle(); rs2_id = 3'd2; settle();
    n_checks++; if (rs2_ready !== 1'b1) begin n_fail++; $display("FAIL byp_stored_ready: got %0b want 1", rs2_ready); end
    n_checks++; if (rs2_val !== 32'h55) begin n_fail++; $display("FAIL byp_stored_val: got %h want 55", rs2_val); end
  endtask

  task automatic test_branch_ok();
    do_reset();
    idle(); issue_valid = 1'b1; issue_is_branch = 1'b1; issue_pred_taken = 1'b1; issue_alt_pc = 32'h200;
    tick();
    cdb(3'd0, 32'd0, 1'b1);
    idle(); settle();
    tick();
    idle(); settle();
    n_checks++; if (clear_flag !== 1'b0) begin n_fail++; $display("FAIL br_ok_no_clear: got %0b want 0", clear_flag); end
    n_checks++; if (write_ROB_id !== 3'd1) begin n_fail++; $display("FAIL br_ok_retired: got %0d want 1", write_ROB_id); end
  endtask

  task automatic test_mispredict();
    do_reset();
    idle(); issue_valid = 1'b1; issue_is_branch = 1'b1; issue_pred_taken = 1'b0; issue_alt_pc = 32'h100;
    tick();
    issue(5'd7);
    cdb(3'd0, 32'd0, 1'b1);
    idle(); settle();
    n_checks++; if (clear_flag !== 1'b0) begin n_fail++; $display("FAIL mp_not_yet: got %0b want 0", clear_flag); end
    tick();
    idle(); issue_valid = 1'b1; issue_rd = 5'd9; cdb_valid = 1'b1; cdb_rob_id = 3'd1; cdb_val = 32'h99; settle();
    n_checks++; if (clear_flag !== 1'b1) begin n_fail++; $display("FAIL mp_clear_flag: got %0b want 1", clear_flag); end
    n_checks++; if (redirect_pc !== 32'h100) begin n_fail++; $display("FAIL mp_redirect_pc: got %h want 100", redirect_pc); end
    n_checks++; if (issue_rob_id !== 3'd0) begin n_fail++; $display("FAIL mp_tail_zero: got %0d want 0", issue_rob_id); end
    n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL mp_full_during_clear: got %0b want 1", full); end
    n_checks++; if (new_reg_id !== 5'd0) begin n_fail++; $display("FAIL mp_issue_ignored: got %0d want 0", new_reg_id); end
    tick();
    idle(); issue_valid = 1'b1; issue_rd = 5'd6; settle();
    n_checks++; if (clear_flag !== 1'b0) begin n_fail++; $display("FAIL mp_clear_one_cycle: got %0b want 0", clear_flag); end
    n_checks++; if (new_ROB_id !== 3'd0) begin n_fail++; $display("FAIL mp_restart_slot: got %0d want 0", new_ROB_id); end
    n_checks++; if (new_reg_id !== 5'd6) begin n_fail++; $display("FAIL mp_restart_issue: got %0d want 6", new_reg_id); end
    tick();
    cdb(3'd0, 32'h66, 1'b0);
    idle(); settle();
    n_checks++; if (write_reg_id !== 5'd6) begin n_fail++; $display("FAIL mp_restart_commit: got %0d want 6", write_reg_id); end
    tick();
    idle(); settle();
    n_checks++; if (write_reg_id !== 5'd0) begin n_fail++; $display("FAIL mp_flushed_entry: got %0d want 0", write_reg_id); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 5; i++) issue(5'(10 + i));
    cdb(3'd0, 32'hBEEF, 1'b0);
    idle(); rst_in = 1'b1;
    tick();
    idle(); rs1_id = 3'd0; settle();
    n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL rm_full: got %0b want 0", full); end
    n_checks++; if (issue_rob_id !== 3'd0) begin n_fail++; $display("FAIL rm_tail: got %0d want 0", issue_rob_id); end
    n_checks++; if (write_reg_id !== 5'd0) begin n_fail++; $display("FAIL rm_no_commit: got %0d want 0", write_reg_id); end
    n_checks++; if (write_ROB_id !== 3'd0) begin n_fail++; $display("FAIL rm_head: got %0d want 0", write_ROB_id); end
    n_checks++; if (rs1_ready !== 1'b0) begin n_fail++; $display("FAIL rm_ready_cleared: got %0b want 0", rs1_ready); end
    tick();
    cdb(3'd0, 32'h1, 1'b0);
    idle(); settle();
    n_checks++; if (write_reg_id !== 5'd0) begin n_fail++; $display("FAIL rm_cdb_ignored: got %0d want 0", write_reg_id); end
  endtask

  task automatic test_stall();
    do_reset();
    issue(5'd2);
    cdb(3'd0, 32'h77, 1'b0);
    idle(); rdy_in = 1'b0; issue_valid = 1'b1; issue_rd = 5'd8; settle();
    n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL st_full: got %0b want 1", full); end
    n_checks++; if (write_reg_id !== 5'd0) begin n_fail++; $display("FAIL st_no_commit: got %0d want 0", write_reg_id); end
    n_checks++; if (new_reg_id !== 5'd0) begin n_fail++; $display("FAIL st_no_issue: got %0d want 0", new_reg_id); end
    tick();
    idle(); settle();
    n_checks++; if (write_reg_id !== 5'd2) begin n_fail++; $display("FAIL st_resume_commit: got %0d want 2", write_reg_id); end
    n_checks++; if (write_val !== 32'h77) begin n_fail++; $display("FAIL st_resume_val: got %h want 77", write_val); end
    n_checks++; if (issue_rob_id !== 3'd1) begin n_fail++; $display("FAIL st_tail_frozen: got %0d want 1", issue_rob_id); end
  endtask

  initial begin
    idle();
    #2;
    test_reset();
    test_issue_commit();
    test_full_wrap();
    test_out_of_order();
    test_bypass();
    test_branch_ok();
    test_mispredict();
    test_reset_mid();
    test_stall();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
